// File: rtl/sprite_pkg.sv
// Shared sprite geometry, sprite id encoding and row helpers for the display path.
package sprite_pkg;

  localparam int SPRITE_ROWS = 32;
  localparam int SPRITE_W    = 32;
  localparam int ROM_AW      = 8;
  localparam int ROW_W       = $clog2(SPRITE_ROWS);
  localparam int ID_W        = ROM_AW - ROW_W;

  typedef enum logic [ID_W-1:0] {
    SPR_PAC_R = ID_W'(0),
    SPR_PAC_L = ID_W'(1),
    SPR_PAC_D = ID_W'(2),
    SPR_PAC_U = ID_W'(3),
    SPR_GHOST = ID_W'(4)
  } sprite_id_e;

  localparam int N_SPRITE_IDS = int'(SPR_GHOST) + 1;

  // Mirror a row left-to-right: out[k] = in[31-k].
  function automatic logic [SPRITE_W-1:0] bitrev32(input logic [SPRITE_W-1:0] x);
    logic [SPRITE_W-1:0] r;
    r = '0;
    for (int k = 0; k < SPRITE_W; k++) begin
      r[k] = x[SPRITE_W-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] upper;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Requesters strictly after the pointer win first; otherwise wrap to index 0.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_upper
      assign upper[gi] = (IW'(gi) > ptr_i);
    end
  endgenerate

  assign masked = req_i & upper;
  assign pick   = (|masked) ? masked : req_i;
  assign any_o  = |req_i;

  always_comb begin
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pick[j]) begin
        idx_o = IW'(j);
      end
    end
  end

  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares one combinational sprite-row ROM between several sprite engines with a
// round-robin grant, a registered address stage and a registered (optionally mirrored) data stage.
module sprite_fetch_scheduler
  import sprite_pkg::*;
#(
  parameter int N_REQ     = 5,
  parameter int N_SPRITES = N_SPRITE_IDS
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    fetch_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [ID_W*N_REQ-1:0]   req_sprite,
  input  logic [ROW_W*N_REQ-1:0]  req_row,
  input  logic [N_REQ-1:0]        req_hflip,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ROM_AW-1:0]       rom_addr,
  input  logic [SPRITE_W-1:0]     rom_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [SPRITE_W-1:0]     rsp_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]  spr_a [N_REQ];
  logic [ROW_W-1:0] row_a [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign spr_a[gi] = req_sprite[ID_W*gi +: ID_W];
      assign row_a[gi] = req_row[ROW_W*gi +: ROW_W];
    end
  endgenerate

  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                a_vld_q, a_vld_d;
  logic [IW-1:0]       a_idx_q, a_idx_d;
  logic                a_flip_q, a_flip_d;
  logic                a_bad_q, a_bad_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [SPRITE_W-1:0] rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic [ID_W-1:0]  win_sprite;
  logic [ROW_W-1:0] win_row;

  // Grants depend only on requests and the pointer, never on the response side.
  assign cand = req_valid & {N_REQ{fetch_en & ~Reset}};

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign req_ready  = gnt;
  assign win_sprite = spr_a[win_idx];
  assign win_row    = row_a[win_idx];

  always_comb begin
    rr_ptr_d   = win_any ? win_idx : rr_ptr_q;
    rom_addr_d = win_any ? {win_sprite, win_row} : rom_addr_q;
    a_vld_d    = win_any;
    a_idx_d    = win_idx;
    a_flip_d   = req_hflip[win_idx];
    a_bad_d    = (int'(win_sprite) >= N_SPRITES);

    rsp_valid_d = a_vld_q ? (N_REQ'(1) << a_idx_q) : '0;
    rsp_data_d  = rsp_data_q;
    if (a_vld_q) begin
      rsp_data_d = a_bad_q ? '0 : (a_flip_q ? bitrev32(rom_data) : rom_data);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q    <= IW'(N_REQ - 1);
      rom_addr_q  <= '0;
      a_vld_q     <= 1'b0;
      a_idx_q     <= '0;
      a_flip_q    <= 1'b0;
      a_bad_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rom_addr_q  <= rom_addr_d;
      a_vld_q     <= a_vld_d;
      a_idx_q     <= a_idx_d;
      a_flip_q    <= a_flip_d;
      a_bad_q     <= a_bad_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  a_ready_onehot: assert property (@(posedge Clk) disable iff (Reset) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge Clk) disable iff (Reset) $onehot0(rsp_valid));

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Randomized and directed stimulus for sprite_fetch_scheduler with a queue-based scoreboard.
module tb_sprite_fetch_scheduler;
  import sprite_pkg::*;

  localparam int N = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          fetch_en;
  logic [N-1:0]  req_valid;
  logic [3*N-1:0] req_sprite;
  logic [5*N-1:0] req_row;
  logic [N-1:0]  req_hflip;
  logic [N-1:0]  req_ready;
  logic [7:0]    rom_addr;
  logic [31:0]   rom_data;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 Clk = ~Clk;

  sprite_fetch_scheduler #(.N_REQ(N), .N_SPRITES(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .fetch_en   (fetch_en),
    .req_valid  (req_valid),
    .req_sprite (req_sprite),
    .req_row    (req_row),
    .req_hflip  (req_hflip),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  typedef struct {
    int          due;
    logic [N-1:0] vld;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          drv_cyc = 0;
  int          mon_cyc = 0;
  bit          mon_en = 0;
  int          m_rr = N - 1;
  logic [31:0] last_data = '0;
  bit          addr_chk = 0;
  logic [7:0]  exp_addr = '0;

  function automatic logic [31:0] mirror(input logic [31:0] x);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = x[31-k];
    return r;
  endfunction

  // One clock of reference behaviour: check the grant and queue the expected response.
  task automatic tick(output int win);
    logic [N-1:0] cand;
    logic [N-1:0] exp_rdy;
    logic [2:0]   spr;
    logic [4:0]   row;
    logic [7:0]   addr;
    exp_t         e;
    @(negedge Clk);
    drv_cyc++;
    if (addr_chk) begin
      checks++;
      if (rom_addr !== exp_addr) begin
        failures++;
        $display("FAIL rom_addr cyc=%0d got=%h exp=%h", drv_cyc, rom_addr, exp_addr);
      end
    end
    cand = (fetch_en && !Reset) ? req_valid : '0;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (win < 0 && cand[j]) win = j;
    end
    exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", drv_cyc, req_ready, exp_rdy);
    end
    addr_chk = 0;
    if (win >= 0) begin
      spr  = req_sprite[3*win +: 3];
      row  = req_row[5*win +: 5];
      addr = {spr, row};
      exp_addr = addr;
      addr_chk = 1;
      e.due  = drv_cyc + 2;
      e.vld  = exp_rdy;
      e.data = (spr >= 3'd5) ? 32'h0 : (req_hflip[win] ? mirror(rom[addr]) : rom[addr]);
      sbq.push_back(e);
      m_rr = win;
    end
    @(posedge Clk);
    #1;
    if (Reset) begin
      sbq.delete();
      m_rr      = N - 1;
      last_data = '0;
      exp_addr  = '0;
      addr_chk  = 1;
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [2:0] s,
                         input logic [4:0] r, input bit f);
    req_valid[i]       = v;
    req_sprite[3*i +: 3] = s;
    req_row[5*i +: 5]  = r;
    req_hflip[i]       = f;
  endtask

  // Scoreboard monitor: pops the expected response when due, otherwise expects silence.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      mon_cyc++;
      if (mon_en) begin
        checks++;
        if (sbq.size() > 0 && sbq[0].due == mon_cyc) begin
          e = sbq.pop_front();
          if (rsp_valid !== e.vld || rsp_data !== e.data) begin
            failures++;
            $display("FAIL rsp cyc=%0d got vld=%b data=%h exp vld=%b data=%h",
                     mon_cyc, rsp_valid, rsp_data, e.vld, e.data);
          end
          last_data = e.data;
        end else if (rsp_valid !== '0 || rsp_data !== last_data) begin
          failures++;
          $display("FAIL rsp_idle cyc=%0d got vld=%b data=%h exp vld=0 data=%h",
                   mon_cyc, rsp_valid, rsp_data, last_data);
        end
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[{3'd4, 5'd5}]  = 32'h001F_FC00;
    rom[{3'd0, 5'd15}] = 32'h1FFF_8000;

    Reset = 1'b1; fetch_en = 1'b1;
    req_valid = '0; req_sprite = '0; req_row = '0; req_hflip = '0;
    repeat (3) tick(w);
    Reset = 1'b0;
    mon_en = 1;

    // single fetch: sprite 4 row 5
    set_req(0, 1, 3'd4, 5'd5, 0);
    tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // sprite 0 row 15, plain then mirrored
    set_req(0, 1, 3'd0, 5'd15, 0);
    tick(w);
    set_req(0, 1, 3'd0, 5'd15, 1);
    tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // all requesters held from reset
    Reset = 1'b1;
    tick(w);
    Reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 3'(i), 5'(3 * i + 1), i[0]);
    repeat (10) tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // invalid sprite id
    set_req(2, 1, 3'd6, 5'd3, 0);
    tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // fetch_en low with everyone waiting, then resume
    req_valid = '1;
    tick(w);
    fetch_en = 1'b0;
    repeat (6) tick(w);
    fetch_en = 1'b1;
    repeat (3) tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // reset one cycle after a grant
    set_req(1, 1, 3'd2, 5'd9, 1);
    tick(w);
    req_valid = '0;
    Reset = 1'b1;
    tick(w);
    Reset = 1'b0;
    req_valid = '1;
    tick(w);
    req_valid = '0;
    repeat (3) tick(w);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      fetch_en = ($urandom_range(0, 7) != 0);
      Reset    = ($urandom_range(0, 99) == 0);
      tick(w);
      Reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i == w || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end

    req_valid = '0;
    repeat (5) tick(w);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
